// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage sequencers.
//
// Contents:
//   N_POINTS_DEF, LOG2N, DATA_WIDTH, TW_IDX_WIDTH : default build constants
//   state_e                                      : sequencer FSM states
//   sin64_q16()                                  : quarter-wave sine on a 64-point grid, Q16
//   scale_q16()                                  : round a non-negative Q16 value to Q<fract>
package fft_pkg;

    localparam int unsigned N_POINTS_DEF = 64;
    localparam int unsigned LOG2N        = 6;
    localparam int unsigned DATA_WIDTH   = 16;
    // Twiddle index spans half the transform length.
    localparam int unsigned TW_IDX_WIDTH = LOG2N - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // round(sin(2*pi*i/64) * 2^16) for i = 0..16; anything else returns 0.
    function automatic int sin64_q16(input int i);
        int v;
        case (i)
            0:       v = 0;
            1:       v = 6424;
            2:       v = 12785;
            3:       v = 19024;
            4:       v = 25080;
            5:       v = 30893;
            6:       v = 36410;
            7:       v = 41576;
            8:       v = 46341;
            9:       v = 50660;
            10:      v = 54491;
            11:      v = 57798;
            12:      v = 60547;
            13:      v = 62714;
            14:      v = 64277;
            15:      v = 65220;
            16:      v = 65536;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Round-half-up rescale of a non-negative Q16 value to Q<fract>.
    function automatic int scale_q16(input int v, input int unsigned fract);
        int r;
        if (fract >= 16) begin
            r = v <<< (fract - 16);
        end else begin
            r = (v + (1 <<< (15 - fract))) >>> (16 - fract);
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle-factor ROM for one SDF FFT stage.
//
// Entry m holds (round(cos(2*pi*m/N) * 2^FRACT_SIZE), round(-sin(2*pi*m/N) * 2^FRACT_SIZE)),
// both signed DW bits, for m = 0..N_POINTS/2-1. Read is purely combinational.
// The constants are derived from a 64-point quarter-wave table, so N_POINTS must be a power of
// two no larger than 64 and FRACT_SIZE must be at most 16 for full precision.
//
// Ports:
//   m    in  : twiddle index
//   w_r  out : cos term
//   w_i  out : -sin term
module twiddle_rom import fft_pkg::*; #(
    parameter int unsigned N_POINTS   = N_POINTS_DEF,
    parameter int unsigned FRACT_SIZE = 8,
    parameter int unsigned DW         = DATA_WIDTH,
    parameter int unsigned MW         = TW_IDX_WIDTH
) (
    input  logic [MW-1:0]        m,
    output logic signed [DW-1:0] w_r,
    output logic signed [DW-1:0] w_i
);

    localparam int unsigned DEPTH = N_POINTS / 2;
    // Stride through the 64-point grid for smaller transforms.
    localparam int unsigned STEP  = 64 / N_POINTS;

    logic signed [DW-1:0] cos_tbl  [DEPTH];
    logic signed [DW-1:0] msin_tbl [DEPTH];

    for (genvar e = 0; e < DEPTH; e++) begin : g_tbl
        localparam int J  = e * int'(STEP);
        // Angle on the 64 grid lies in [0, pi); fold onto the first quadrant.
        localparam int CS = (J <= 16) ? scale_q16(sin64_q16(16 - J), FRACT_SIZE)
                                      : -scale_q16(sin64_q16(J - 16), FRACT_SIZE);
        localparam int MS = (J <= 16) ? -scale_q16(sin64_q16(J), FRACT_SIZE)
                                      : -scale_q16(sin64_q16(32 - J), FRACT_SIZE);
        assign cos_tbl[e]  = DW'(CS);
        assign msin_tbl[e] = DW'(MS);
    end

    always_comb begin
        w_r = cos_tbl[m];
        w_i = msin_tbl[m];
    end

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Sequencer for one radix-2 DIF stage of the SDF FFT.
//
// Counts samples leaving the stage butterfly, derives the twiddle index, looks the twiddle up
// and drives the external complex multiplier. Valid and frame markers are registered once so
// they line up with the multiplier's one-cycle product register.
//
// Build option: define TRIVIAL_TWIDDLE_BYPASS_EN to route W=1 and W=-j samples around the
// multiplier through a local register (multiplier operands forced to 0 on those cycles).
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid, in_r, in_i  : butterfly output sample
//   mul_in1_r/i           : data operand to the multiplier
//   mul_in2_r/i           : twiddle operand to the multiplier
//   mul_out_r/i           : multiplier product (one cycle after its operands)
//   out_valid, out_r/i    : twiddled sample to the next stage
//   frame_start           : marks the output of sample k=0
//   frame_done            : marks the output of sample k=N_POINTS-1
//   busy                  : high in RUN and DRAIN
module fft_twiddle_sequencer import fft_pkg::*; #(
    parameter  int unsigned N_POINTS     = N_POINTS_DEF,
    parameter  int unsigned STAGE        = 0,
    parameter  int unsigned INTEGER_SIZE = 8,
    parameter  int unsigned FRACT_SIZE   = 8,
    localparam int unsigned DW           = INTEGER_SIZE + FRACT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic signed [DW-1:0] mul_in1_r,
    output logic signed [DW-1:0] mul_in1_i,
    output logic signed [DW-1:0] mul_in2_r,
    output logic signed [DW-1:0] mul_in2_i,
    input  logic signed [DW-1:0] mul_out_r,
    input  logic signed [DW-1:0] mul_out_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int unsigned LG      = $clog2(N_POINTS);
    localparam int unsigned MW      = LG - 1;
    localparam int unsigned BLK_LEN = N_POINTS >> STAGE;
    localparam int unsigned HALF    = BLK_LEN / 2;
    localparam logic [LG-1:0] K_LAST = LG'(N_POINTS - 1);

    state_e state_q, state_d;

    logic [LG-1:0] k_q, k_d;
    logic          out_valid_q;
    logic          frame_start_q;
    logic          frame_done_q;

    logic [LG-1:0] p;
    logic [LG-1:0] off;
    logic [MW-1:0] m;

    logic signed [DW-1:0] w_r, w_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // frame_done_q is high the cycle after sample N-1 was accepted.
                if (frame_done_q && !in_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = in_valid ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
    end

    // ------------------------------------------------------------------
    // Sample counter and markers aligned to the product register
    // ------------------------------------------------------------------
    always_comb begin
        // Power-of-two length, so natural wrap takes N-1 back to 0.
        k_d = in_valid ? k_q + 1'b1 : k_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q           <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            k_q           <= k_d;
            out_valid_q   <= in_valid;
            frame_start_q <= in_valid && (k_q == '0);
            frame_done_q  <= in_valid && (k_q == K_LAST);
        end
    end

    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

    // ------------------------------------------------------------------
    // Twiddle index: upper half of each block gets a rotating twiddle
    // ------------------------------------------------------------------
    always_comb begin
        p   = k_q & LG'(BLK_LEN - 1);
        off = (p - LG'(HALF)) << STAGE;
        m   = (p < LG'(HALF)) ? '0 : MW'(off);
    end

    twiddle_rom #(
        .N_POINTS   (N_POINTS),
        .FRACT_SIZE (FRACT_SIZE),
        .DW         (DW),
        .MW         (MW)
    ) u_twiddle_rom (
        .m   (m),
        .w_r (w_r),
        .w_i (w_i)
    );

`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
    localparam logic [MW-1:0] M_NEG_J = MW'(N_POINTS / 4);

    logic                 bypass;
    logic                 byp_q;
    logic signed [DW-1:0] byp_r_d, byp_i_d;
    logic signed [DW-1:0] byp_r_q, byp_i_q;

    always_comb begin
        bypass  = (m == '0) || (m == M_NEG_J);
        byp_r_d = in_r;
        byp_i_d = in_i;
        // (a + jb) * -j = b - ja
        if (m == M_NEG_J) begin
            byp_r_d = in_i;
            byp_i_d = -in_r;
        end
        // Idle the multiplier on trivial twiddles.
        mul_in1_r = bypass ? '0 : in_r;
        mul_in1_i = bypass ? '0 : in_i;
        mul_in2_r = bypass ? '0 : w_r;
        mul_in2_i = bypass ? '0 : w_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q   <= 1'b0;
            byp_r_q <= '0;
            byp_i_q <= '0;
        end else if (in_valid) begin
            byp_q   <= bypass;
            byp_r_q <= byp_r_d;
            byp_i_q <= byp_i_d;
        end
    end

    always_comb begin
        out_r = byp_q ? byp_r_q : mul_out_r;
        out_i = byp_q ? byp_i_q : mul_out_i;
    end
`else
    always_comb begin
        mul_in1_r = in_r;
        mul_in1_i = in_i;
        mul_in2_r = w_r;
        mul_in2_i = w_i;
        out_r     = mul_out_r;
        out_i     = mul_out_i;
    end
`endif

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
module tb_fft_twiddle_sequencer;

    localparam int N  = 64;
    localparam int FR = 8;
    localparam int DW = 16;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int r;
        int i;
        bit fs;
        bit fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;

    always #5 clk = ~clk;

    // Two instances share the input stream: stage 0 and stage 1.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic signed [DW-1:0] mul_in1_r, mul_in1_i, mul_in2_r, mul_in2_i;
        logic signed [DW-1:0] mul_out_r, mul_out_i;
        logic signed [DW-1:0] out_r, out_i;
        logic out_valid, frame_start, frame_done, busy;

        fft_twiddle_sequencer #(
            .N_POINTS     (N),
            .STAGE        (g),
            .INTEGER_SIZE (8),
            .FRACT_SIZE   (FR)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_r        (in_r),
            .in_i        (in_i),
            .mul_in1_r   (mul_in1_r),
            .mul_in1_i   (mul_in1_i),
            .mul_in2_r   (mul_in2_r),
            .mul_in2_i   (mul_in2_i),
            .mul_out_r   (mul_out_r),
            .mul_out_i   (mul_out_i),
            .out_valid   (out_valid),
            .out_r       (out_r),
            .out_i       (out_i),
            .frame_start (frame_start),
            .frame_done  (frame_done),
            .busy        (busy)
        );

        // External multiplier: one product register, truncate and wrap.
        always @(posedge clk) begin
            mul_out_r <= DW'((int'(mul_in1_r) * int'(mul_in2_r)
                            - int'(mul_in1_i) * int'(mul_in2_i)) >>> FR);
            mul_out_i <= DW'((int'(mul_in1_r) * int'(mul_in2_i)
                            + int'(mul_in1_i) * int'(mul_in2_r)) >>> FR);
        end
    end

    // Scoreboards, one per instance.
    exp_t sb0[$];
    exp_t sb1[$];

    // Same-cycle expectations handed from stimulus to monitor.
    bit chk_zero = 0;
    bit chk_mul  = 0;
    bit final_chk = 0;
    int busy_exp = -1;
    int exp_m1r[2], exp_m1i[2], exp_m2r[2], exp_m2i[2];

    int tests = 0;
    int fails = 0;

    int k_model = 0;
    bit rst_prev = 0;

    // ---------------- reference model ----------------
    function automatic int tw_idx(input int k, input int stage);
        int l = N >> stage;
        int h = l / 2;
        int p = k % l;
        return (p < h) ? 0 : (p - h) << stage;
    endfunction

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int wrap16(input int v);
        logic signed [DW-1:0] t = DW'(v);
        return int'(t);
    endfunction

    // ---------------- checking ----------------
    task automatic cmp(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, want);
        end
    endtask

    task automatic pop_check(input int d, input logic ov, input logic signed [DW-1:0] r,
                             input logic signed [DW-1:0] i, input logic fs, input logic fd);
        exp_t e;
        int sz;
        if (ov !== 1'b1) return;
        sz = (d == 0) ? sb0.size() : sb1.size();
        if (sz == 0) begin
            tests++;
            fails++;
            $display("FAIL out dut%0d: got unexpected out_valid, expected no output", d);
            return;
        end
        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        cmp("out", d, {30'd0, r, i, fs, fd}, {30'd0, DW'(e.r), DW'(e.i), e.fs, e.fd});
    endtask

    always @(negedge clk) begin
        if (chk_zero) begin
            cmp("reset", 0, {60'd0, g_dut[0].out_valid, g_dut[0].frame_start,
                             g_dut[0].frame_done, g_dut[0].busy}, 64'd0);
            cmp("reset", 1, {60'd0, g_dut[1].out_valid, g_dut[1].frame_start,
                             g_dut[1].frame_done, g_dut[1].busy}, 64'd0);
        end
        if (chk_mul) begin
            cmp("mul_in", 0, {g_dut[0].mul_in1_r, g_dut[0].mul_in1_i,
                              g_dut[0].mul_in2_r, g_dut[0].mul_in2_i},
                {DW'(exp_m1r[0]), DW'(exp_m1i[0]), DW'(exp_m2r[0]), DW'(exp_m2i[0])});
            cmp("mul_in", 1, {g_dut[1].mul_in1_r, g_dut[1].mul_in1_i,
                              g_dut[1].mul_in2_r, g_dut[1].mul_in2_i},
                {DW'(exp_m1r[1]), DW'(exp_m1i[1]), DW'(exp_m2r[1]), DW'(exp_m2i[1])});
        end
        if (busy_exp >= 0) begin
            cmp("busy", 0, {63'd0, g_dut[0].busy}, 64'(busy_exp));
            cmp("busy", 1, {63'd0, g_dut[1].busy}, 64'(busy_exp));
        end
        pop_check(0, g_dut[0].out_valid, g_dut[0].out_r, g_dut[0].out_i,
                  g_dut[0].frame_start, g_dut[0].frame_done);
        pop_check(1, g_dut[1].out_valid, g_dut[1].out_r, g_dut[1].out_i,
                  g_dut[1].frame_start, g_dut[1].frame_done);
        if (final_chk) begin
            cmp("drained", 0, 64'(sb0.size()), 64'd0);
            cmp("drained", 1, 64'(sb1.size()), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic signed [DW-1:0] r,
                         input logic signed [DW-1:0] i, input bit rs, input int bexp = -1);
        exp_t e;
        @(posedge clk);
        #1;
        chk_zero = rst_prev;
        busy_exp = bexp;
        rst      = rs;
        in_valid = v;
        in_r     = r;
        in_i     = i;
        chk_mul  = v && !rs;
        if (v && !rs) begin
            for (int d = 0; d < 2; d++) begin
                int m = tw_idx(k_model, d);
                real a = 2.0 * PI * real'(m) / real'(N);
                int wr = rnd($cos(a) * 256.0);
                int wi = rnd(-$sin(a) * 256.0);
                exp_m1r[d] = int'(r);
                exp_m1i[d] = int'(i);
                exp_m2r[d] = wr;
                exp_m2i[d] = wi;
`ifdef TRIVIAL_TWIDDLE_BYPASS_EN
                if (m == 0 || m == N / 4) begin
                    exp_m1r[d] = 0;
                    exp_m1i[d] = 0;
                    exp_m2r[d] = 0;
                    exp_m2i[d] = 0;
                end
`endif
                e.r  = wrap16((int'(r) * wr - int'(i) * wi) >>> FR);
                e.i  = wrap16((int'(r) * wi + int'(i) * wr) >>> FR);
                e.fs = (k_model == 0);
                e.fd = (k_model == N - 1);
                if (d == 0) sb0.push_back(e);
                else sb1.push_back(e);
            end
            k_model = (k_model + 1) % N;
        end
        if (rs) k_model = 0;
        rst_prev = rs;
    endtask

    function automatic logic signed [DW-1:0] rdat();
        return DW'($urandom);
    endfunction

    initial begin
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);

        // Frame with directed samples at k=5 and k=48 and a 3-cycle gap before k=10.
        for (int n = 0; n < 5; n++) drive(1, rdat(), rdat(), 0);
        drive(1, 16'sd100, -16'sd50, 0);
        for (int n = 6; n < 10; n++) drive(1, rdat(), rdat(), 0);
        for (int n = 0; n < 3; n++) drive(0, rdat(), rdat(), 0, 1);
        for (int n = 10; n < 48; n++) drive(1, rdat(), rdat(), 0);
        drive(1, 16'sd256, 16'sd0, 0);
        for (int n = 49; n < 64; n++) drive(1, rdat(), rdat(), 0);

        // Two back-to-back frames, then wind down to idle.
        drive(0, 0, 0, 1);
        for (int n = 0; n < 2 * N; n++) drive(1, rdat(), rdat(), 0, (n == 0) ? -1 : 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Reset mid-frame at k=20, colliding with a valid sample.
        for (int n = 0; n < 20; n++) drive(1, rdat(), rdat(), 0);
        drive(1, rdat(), rdat(), 1);
        for (int n = 0; n < 8; n++) drive(1, rdat(), rdat(), 0);

        // Random traffic with gaps and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom % 4) != 0, rdat(), rdat(), ($urandom % 250) == 0);
        end

        for (int n = 0; n < 4; n++) drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_zero = 0;
        chk_mul  = 0;
        busy_exp = -1;
        final_chk = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        final_chk = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
